pkt_buffer_rd_sequencer: RTL and testbench

//  Dequeue controller for the shared packet buffer (address manager plus data/meta BRAMs).

---
 rtl/pifo_sched_pkg.sv | 17 +
 rtl/pkt_buffer_rd_sequencer.sv | 111 +++++++++++
 tb/tb_pkt_buffer_rd_sequencer.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pifo_sched_pkg.sv
// Shared definitions for the PIFO scheduler dequeue path: FSM encodings and default widths.
package pifo_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_STREAM = 2'd2
    } rd_state_t;

    localparam int DEF_ADDR_WIDTH    = 12;
    localparam int DEF_DATA_WIDTH    = 256;
    localparam int DEF_TUSER_WIDTH   = 128;
    localparam int DEF_MAX_PKT_WORDS = 64;
    localparam int DEF_STAT_WIDTH    = 32;
    localparam int WCNT_WIDTH        = 16;

endpackage

// File: rtl/pkt_buffer_rd_sequencer.sv
// Dequeue controller: takes one SOP address per packet, loads the buffer tail, then
// streams buffer words out as an AXI4-Stream master with full backpressure.
module pkt_buffer_rd_sequencer
    import pifo_sched_pkg::*;
#(
    parameter int ADDR_WIDTH           = DEF_ADDR_WIDTH,
    parameter int C_M_AXIS_DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int C_M_AXIS_TUSER_WIDTH = DEF_TUSER_WIDTH,
    parameter int MAX_PKT_WORDS        = DEF_MAX_PKT_WORDS,
    parameter int STAT_WIDTH           = DEF_STAT_WIDTH
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              pause,

    input  logic [ADDR_WIDTH-1:0]             s_axis_sop_addr,
    input  logic                              s_axis_sop_valid,
    output logic                              s_axis_sop_ready,

    output logic                              m_axis_rd_first_word_en,
    output logic [ADDR_WIDTH-1:0]             m_axis_rd_pkt_sop_addr,
    output logic                              m_axis_rd_en,

    input  logic [C_M_AXIS_DATA_WIDTH-1:0]    s_axis_buf_tdata,
    input  logic [C_M_AXIS_DATA_WIDTH/8-1:0]  s_axis_buf_tkeep,
    input  logic                              s_axis_buf_tlast,
    input  logic [C_M_AXIS_TUSER_WIDTH-1:0]   s_axis_buf_tuser,
    input  logic                              s_axis_buf_is_empty,

    output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tlast,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,

    output logic [STAT_WIDTH-1:0]             stat_pkt_count,
    output logic [STAT_WIDTH-1:0]             stat_word_count,
    output logic                              err_overlength
);

    localparam logic [WCNT_WIDTH-1:0] LAST_IDX = WCNT_WIDTH'(MAX_PKT_WORDS - 1);

    rd_state_t               state, state_nxt;
    logic [ADDR_WIDTH-1:0]   sop_addr_q;
    logic [WCNT_WIDTH-1:0]   word_cnt;
    logic [STAT_WIDTH-1:0]   pkt_cnt_q, wrd_cnt_q;
    logic                    err_q;

    logic tvalid, beat, force_last, last, last_beat, sop_ready, accept;

    always_comb begin
        tvalid     = (state == ST_STREAM) && !s_axis_buf_is_empty;
        beat       = tvalid && m_axis_tready;
        // Beat number MAX_PKT_WORDS is the current word when word_cnt == MAX_PKT_WORDS-1.
        force_last = (word_cnt == LAST_IDX);
        last       = s_axis_buf_tlast || force_last;
        last_beat  = beat && last;
        // Ready is also offered on the last beat so back-to-back packets lose only the LOAD cycle.
        sop_ready  = !rst && !pause && ((state == ST_IDLE) || last_beat);
        accept     = sop_ready && s_axis_sop_valid;

        state_nxt = state;
        case (state)
            ST_IDLE:   if (accept) state_nxt = ST_LOAD;
            ST_LOAD:   state_nxt = ST_STREAM;
            ST_STREAM: if (last_beat) state_nxt = accept ? ST_LOAD : ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Data outputs are gated by tvalid so an idle or reset sequencer drives zeros.
    always_comb begin
        s_axis_sop_ready        = sop_ready;
        m_axis_rd_first_word_en = (state == ST_LOAD);
        m_axis_rd_pkt_sop_addr  = sop_addr_q;
        m_axis_rd_en            = beat;
        m_axis_tvalid           = tvalid;
        m_axis_tdata            = tvalid ? s_axis_buf_tdata : '0;
        m_axis_tkeep            = tvalid ? s_axis_buf_tkeep : '0;
        m_axis_tuser            = tvalid ? s_axis_buf_tuser : '0;
        m_axis_tlast            = tvalid && last;
        stat_pkt_count          = pkt_cnt_q;
        stat_word_count         = wrd_cnt_q;
        err_overlength          = err_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            sop_addr_q <= '0;
            word_cnt   <= '0;
            pkt_cnt_q  <= '0;
            wrd_cnt_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept)
                sop_addr_q <= s_axis_sop_addr;
            if (beat) begin
                wrd_cnt_q <= wrd_cnt_q + STAT_WIDTH'(1);
                word_cnt  <= last ? '0 : word_cnt + WCNT_WIDTH'(1);
            end
            if (last_beat)
                pkt_cnt_q <= pkt_cnt_q + STAT_WIDTH'(1);
            if (beat && force_last && !s_axis_buf_tlast)
                err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pkt_buffer_rd_sequencer.sv
// Directed bench for pkt_buffer_rd_sequencer with a small behavioural packet buffer model.
module tb_pkt_buffer_rd_sequencer;

    localparam int AW = 12;
    localparam int DW = 256;
    localparam int UW = 128;

    logic          clk = 1'b0;
    logic          rst;
    logic          pause;
    logic [AW-1:0] sop_addr;
    logic          sop_valid, sop_ready;
    logic          fwe;
    logic [AW-1:0] rd_addr;
    logic          rd_en;
    logic [DW-1:0] buf_tdata;
    logic [DW/8-1:0] buf_tkeep;
    logic          buf_tlast;
    logic [UW-1:0] buf_tuser;
    logic          buf_empty;
    logic [DW-1:0] tdata;
    logic [DW/8-1:0] tkeep;
    logic [UW-1:0] tuser;
    logic          tlast, tvalid, tready;
    logic [31:0]   pkt_cnt, wrd_cnt;
    logic          err;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pkt_buffer_rd_sequencer dut (
        .clk(clk), .rst(rst), .pause(pause),
        .s_axis_sop_addr(sop_addr), .s_axis_sop_valid(sop_valid), .s_axis_sop_ready(sop_ready),
        .m_axis_rd_first_word_en(fwe), .m_axis_rd_pkt_sop_addr(rd_addr), .m_axis_rd_en(rd_en),
        .s_axis_buf_tdata(buf_tdata), .s_axis_buf_tkeep(buf_tkeep), .s_axis_buf_tlast(buf_tlast),
        .s_axis_buf_tuser(buf_tuser), .s_axis_buf_is_empty(buf_empty),
        .m_axis_tdata(tdata), .m_axis_tkeep(tkeep), .m_axis_tuser(tuser), .m_axis_tlast(tlast),
        .m_axis_tvalid(tvalid), .m_axis_tready(tready),
        .stat_pkt_count(pkt_cnt), .stat_word_count(wrd_cnt), .err_overlength(err)
    );

    // Buffer model: tail pointer loaded by first_word_en, advanced by rd_en; word content encodes its address.
    logic [AW-1:0] tail;
    bit            mem_last [0:4095];

    always_ff @(posedge clk) begin
        if (rst)       tail <= '0;
        else if (fwe)  tail <= rd_addr;
        else if (rd_en) tail <= tail + 12'd1;
    end

    assign buf_tdata = {16'hBEEF, 228'h0, tail};
    assign buf_tkeep = '1;
    assign buf_tuser = {116'h0, tail};
    assign buf_tlast = mem_last[tail];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic pause, valid;
        logic [AW-1:0] addr;
        logic tready, empty;
        logic e_rdy, e_fwe, e_rd, e_tv, e_tl;
        logic [AW-1:0] e_word;
    } vec_t;

    function automatic vec_t mk(logic p, logic v, logic [AW-1:0] a, logic r, logic e,
                                logic erdy, logic efwe, logic erd, logic etv, logic etl,
                                logic [AW-1:0] ew);
        vec_t t;
        t.pause = p; t.valid = v; t.addr = a; t.tready = r; t.empty = e;
        t.e_rdy = erdy; t.e_fwe = efwe; t.e_rd = erd; t.e_tv = etv; t.e_tl = etl; t.e_word = ew;
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // IDLE accept cycle followed by the LOAD cycle.
    task automatic start_pkt(input logic [AW-1:0] a);
        sop_valid = 1'b1; sop_addr = a; tready = 1'b1; buf_empty = 1'b0;
        @(negedge clk);
        chk("accept_ready", sop_ready, 1);
        tick();
        sop_valid = 1'b0;
        @(negedge clk);
        chk("load_fwe", fwe, 1);
        chk("load_addr", rd_addr, a);
        chk("load_no_rd_en", rd_en, 0);
        chk("load_no_tvalid", tvalid, 0);
        tick();
    endtask

    // Streams one packet; mode 1 applies a backpressure/empty pattern.
    task automatic run_pkt(input logic [AW-1:0] base, input int exp_beats, input int mode);
        logic rdy_pat [7] = '{1, 0, 0, 1, 1, 1, 1};
        logic emp_pat [7] = '{0, 0, 0, 0, 1, 0, 0};
        int beats = 0;
        int rds = 0;
        bit stalled = 0;
        bit done = 0;
        logic [DW-1:0] prev_data = '0;
        logic prev_last = 0;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            tready    = (mode == 1 && cyc < 7) ? rdy_pat[cyc] : 1'b1;
            buf_empty = (mode == 1 && cyc < 7) ? emp_pat[cyc] : 1'b0;
            @(negedge clk);
            chk("stream_tvalid", tvalid, !buf_empty);
            chk("stream_rd_en", rd_en, !buf_empty && tready);
            if (stalled && tvalid) begin
                chk("hold_tdata", tdata, prev_data);
                chk("hold_tlast", tlast, prev_last);
            end
            if (rd_en) rds++;
            if (tvalid && tready) begin
                chk("beat_word", tdata[AW-1:0], base + AW'(beats));
                chk("beat_tlast", tlast, beats == exp_beats - 1);
                if (tlast) done = 1;
                beats++;
            end
            stalled   = tvalid && !tready;
            prev_data = tdata;
            prev_last = tlast;
            tick();
        end
        chk("pkt_beats", beats, exp_beats);
        chk("pkt_rd_en_count", rds, beats);
        tready = 1'b1; buf_empty = 1'b0;
    endtask

    vec_t vecs [16];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd_cnt;
        for (int i = 0; i < 4096; i++) mem_last[i] = 0;
        mem_last[12'h007] = 1;
        mem_last[12'h011] = 1;
        mem_last[12'h023] = 1;
        mem_last[12'h043] = 1;
        mem_last[12'h145] = 1;
        mem_last[12'h204] = 1;

        // Test 1: 3-word packet at 0x005
        vecs[0]  = mk(0, 1, 12'h005, 1, 0,  1, 0, 0, 0, 0, 12'h000);
        vecs[1]  = mk(0, 0, 12'h000, 1, 0,  0, 1, 0, 0, 0, 12'h005);
        vecs[2]  = mk(0, 0, 12'h000, 1, 0,  0, 0, 1, 1, 0, 12'h005);
        vecs[3]  = mk(0, 0, 12'h000, 1, 0,  0, 0, 1, 1, 0, 12'h006);
        vecs[4]  = mk(0, 0, 12'h000, 1, 0,  1, 0, 1, 1, 1, 12'h007);
        vecs[5]  = mk(0, 0, 12'h000, 1, 0,  1, 0, 0, 0, 0, 12'h000);
        // Test 2: 2-word then 4-word packet, second SOP accepted on first tlast beat
        vecs[6]  = mk(0, 1, 12'h010, 1, 0,  1, 0, 0, 0, 0, 12'h000);
        vecs[7]  = mk(0, 1, 12'h020, 1, 0,  0, 1, 0, 0, 0, 12'h010);
        vecs[8]  = mk(0, 1, 12'h020, 1, 0,  0, 0, 1, 1, 0, 12'h010);
        vecs[9]  = mk(0, 1, 12'h020, 1, 0,  1, 0, 1, 1, 1, 12'h011);
        vecs[10] = mk(0, 0, 12'h000, 1, 0,  0, 1, 0, 0, 0, 12'h020);
        vecs[11] = mk(0, 0, 12'h000, 1, 0,  0, 0, 1, 1, 0, 12'h020);
        vecs[12] = mk(0, 0, 12'h000, 1, 0,  0, 0, 1, 1, 0, 12'h021);
        vecs[13] = mk(0, 0, 12'h000, 1, 0,  0, 0, 1, 1, 0, 12'h022);
        vecs[14] = mk(0, 0, 12'h000, 1, 0,  1, 0, 1, 1, 1, 12'h023);
        vecs[15] = mk(0, 0, 12'h000, 1, 0,  1, 0, 0, 0, 0, 12'h000);

        rst = 1'b1; pause = 1'b0; sop_addr = '0; sop_valid = 1'b0; tready = 1'b0; buf_empty = 1'b1;
        tick();
        tick();
        @(negedge clk);
        chk("rst_tvalid", tvalid, 0);
        chk("rst_sop_ready", sop_ready, 0);
        chk("rst_fwe", fwe, 0);
        chk("rst_pkt_cnt", pkt_cnt, 0);
        chk("rst_wrd_cnt", wrd_cnt, 0);
        chk("rst_err", err, 0);
        tick();
        rst = 1'b0;

        rd_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            pause = vecs[i].pause; sop_valid = vecs[i].valid; sop_addr = vecs[i].addr;
            tready = vecs[i].tready; buf_empty = vecs[i].empty;
            @(negedge clk);
            chk($sformatf("v%0d_sop_ready", i), sop_ready, vecs[i].e_rdy);
            chk($sformatf("v%0d_fwe", i), fwe, vecs[i].e_fwe);
            chk($sformatf("v%0d_rd_en", i), rd_en, vecs[i].e_rd);
            chk($sformatf("v%0d_tvalid", i), tvalid, vecs[i].e_tv);
            chk($sformatf("v%0d_tlast", i), tlast, vecs[i].e_tl);
            if (vecs[i].e_fwe) chk($sformatf("v%0d_sop_addr", i), rd_addr, vecs[i].e_word);
            if (vecs[i].e_tv)  chk($sformatf("v%0d_tdata", i), tdata[AW-1:0], vecs[i].e_word);
            if (i >= 6 && rd_en) rd_cnt++;
            if (i == 5) begin
                chk("t1_pkt_cnt", pkt_cnt, 1);
                chk("t1_wrd_cnt", wrd_cnt, 3);
            end
            tick();
        end
        chk("t2_rd_en_pulses", rd_cnt, 6);
        chk("t2_pkt_cnt", pkt_cnt, 3);
        chk("t2_wrd_cnt", wrd_cnt, 9);

        // Test 3: backpressure and an empty stall mid-packet
        start_pkt(12'h040);
        run_pkt(12'h040, 4, 1);
        chk("t3_pkt_cnt", pkt_cnt, 4);
        chk("t3_wrd_cnt", wrd_cnt, 13);

        // Test 4: 70-word packet truncated at 64
        start_pkt(12'h100);
        run_pkt(12'h100, 64, 0);
        @(negedge clk);
        chk("t4_err", err, 1);
        chk("t4_idle_tvalid", tvalid, 0);
        chk("t4_idle_ready", sop_ready, 1);
        chk("t4_pkt_cnt", pkt_cnt, 5);
        chk("t4_wrd_cnt", wrd_cnt, 77);
        tick();

        // Test 5: pause holds off SOP acceptance
        pause = 1'b1; sop_valid = 1'b1; sop_addr = 12'h200;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("t5_paused_ready", sop_ready, 0);
            chk("t5_paused_fwe", fwe, 0);
            tick();
        end
        chk("t5_err_sticky", err, 1);
        pause = 1'b0;
        start_pkt(12'h200);

        // Test 6: reset after 2 of 5 words
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("t6_pre_rd_en", rd_en, 1);
            chk("t6_pre_word", tdata[AW-1:0], 12'h200 + 12'(c));
            tick();
        end
        rst = 1'b1;
        tick();
        @(negedge clk);
        chk("t6_rst_tvalid", tvalid, 0);
        chk("t6_rst_rd_en", rd_en, 0);
        chk("t6_rst_fwe", fwe, 0);
        chk("t6_rst_ready", sop_ready, 0);
        chk("t6_rst_tdata", tdata[63:0], 0);
        chk("t6_rst_addr", rd_addr, 0);
        chk("t6_rst_pkt_cnt", pkt_cnt, 0);
        chk("t6_rst_wrd_cnt", wrd_cnt, 0);
        chk("t6_rst_err", err, 0);
        tick();
        rst = 1'b0;
        start_pkt(12'h200);
        run_pkt(12'h200, 5, 0);
        chk("t6_pkt_cnt", pkt_cnt, 1);
        chk("t6_wrd_cnt", wrd_cnt, 5);
        chk("t6_err", err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
